i2s_sample_tx: RTL and testbench
================================

# i2s_sample_tx

Stereo I2S transmitter on the output side of `pitch_shifter`. It accepts one-cycle-strobed left/right sample pairs on the same interface `pitch_shifter` drives (`out_left`, `out_right`, `out_ready`) and buffers them in a 2-entry FIFO. It serialises the samples MSB-first onto `bclk`/`lrck`/`sdata` for the audio codec DAC, and repeats the last sample pair on underrun.

## Interface
- `DATA_SIZE`, 24: sample width in bits.
- `SLOT_BITS`, 32: BCLK periods per channel slot. Must be ≥ `DATA_SIZE`; unused LSB positions are sent as 0.
- `BCLK_HALF`, 4: `clk` cycles per BCLK half-period. Must be ≥ 1.
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `in_left` in `DATA_SIZE`: left sample, sampled when `in_ready`=1.
- `in_right` in `DATA_SIZE`: right sample, sampled when `in_ready`=1.
- `in_ready` in 1: one-cycle strobe, one stereo pair per strobe.
- `bclk` out 1: bit clock, divided from `clk`.
- `lrck` out 1: word select. 0 = left slot, 1 = right slot.
- `sdata` out 1: serial data, changes only on BCLK falling edges.
- `fifo_level` out 2: pairs currently buffered (0..2).
- `underrun` out 1: one-cycle pulse when a frame starts with the FIFO empty.
- `overflow` out 1: one-cycle pulse when a strobe arrives and the pair cannot be stored.

## Operation
- Clock divider
  - `div_cnt` counts 0..`BCLK_HALF`-1. On wrap, `bclk` toggles.
  - A 0→1 toggle is a "rise"; a 1→0 toggle is a "fall".
- Bit counter
  - `bit_cnt` counts 0..2·`SLOT_BITS`-1 and advances by 1 (mod 2·`SLOT_BITS`) on each fall.
  - `lrck` = (`bit_cnt` ≥ `SLOT_BITS`), registered and updated with `bit_cnt`.
- Frame word
  - W has 2·`SLOT_BITS` bits: {left, zeros, right, zeros}, each slot being `DATA_SIZE` data bits followed by `SLOT_BITS`-`DATA_SIZE` zeros. Index 0 is the left MSB.
  - While `bit_cnt`=b, `sdata` = W[(b-1) mod 2·`SLOT_BITS`]. This gives the standard I2S one-BCLK delay after each `lrck` edge.
  - Implement as a shift register: load on the frame-start fall, shift left on every other fall.
- Frame start: the fall that takes `bit_cnt` from 0 to 1.
  - FIFO non-empty: pop the head pair into W.
  - FIFO empty: reload W from the last popped pair (zeros if none since reset) and pulse `underrun` in that cycle.
- FIFO
  - 2 entries, write pointer, read pointer, 2-bit count.
  - Push on `in_ready` when count < 2; otherwise drop the pair and pulse `overflow`.
- Simultaneous push and pop in the same cycle
  - Count unchanged.
  - When full, the push is accepted: the pop frees the slot first, so there is no overflow.
  - When empty: the pop sees empty and underruns; the push is stored.

## Timing
- Reset values: `bclk`=0, `lrck`=0, `sdata`=0, `fifo_level`=0, `underrun`=0, `overflow`=0. Internally: `div_cnt`=0, `bit_cnt`=0, W=0, last pair=0.
- Reset mid-frame aborts the frame immediately, empties the FIFO, and restarts the timing from the reset state.
- Divider timing after reset release:
  - First rise occurs after `BCLK_HALF` `clk` cycles.
  - First fall (the first frame start) occurs after 2·`BCLK_HALF` `clk` cycles.
- Frame period: 2·`SLOT_BITS`·2·`BCLK_HALF` `clk` cycles. Defaults give 512 cycles, ≈97.7 kHz.
- Push latency: a push updates `fifo_level` on the next `clk` edge.
- Pair-to-output latency: a pushed pair first drives `sdata` at the next frame start. That is ≥1 `clk` after the push; a push in the same cycle as a frame start is not seen by that frame.
- Registered outputs: `underrun` and `overflow` are registered, high for exactly one cycle. `sdata`, `lrck`, and `bit_cnt` all change on the same `clk` edge as the fall.

## Test plan
Parameters for all scenarios unless noted: `DATA_SIZE`=8, `SLOT_BITS`=10, `BCLK_HALF`=2.
- Reset values: assert `rst`=0 mid-run → all outputs immediately at reset values. Release → first rise after 2 `clk` cycles, first fall after 4, `underrun` pulse at the first fall, `sdata`=0 for the whole frame.
- Single pair: push `in_left`=8'hA5, `in_right`=8'h3C before the first frame start → `lrck`=0 slot carries 1,0,1,0,0,1,0,1,0,0 (bits 1..10). `lrck`=1 slot carries 0,0,1,1,1,1,0,0,0,0. Following frame repeats it with an `underrun` pulse.
- Overflow: three strobes in consecutive cycles with the FIFO empty → `fifo_level` 1,2,2; `overflow` pulses once, on the third strobe; only the first two pairs are transmitted, in order.
- Full plus frame start: FIFO full with a strobe in the same cycle as a frame start → no `overflow`, `fifo_level` stays 2, the new pair is transmitted two frames later.
- Default parameters: stream 512 pitch-shifted pairs at one per frame → zero `underrun`/`overflow` after the first frame. The bit-exact deserialised stream equals the input.

Source files
------------

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: stereo I2S transmitter.
// Buffers strobed L/R pairs in a 2-entry FIFO and serialises them MSB-first
// onto bclk/lrck/sdata. The last pair is repeated when a frame starts empty.
module i2s_sample_tx #(
  parameter int DATA_SIZE = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] in_left,
  input  logic [DATA_SIZE-1:0] in_right,
  input  logic                 in_ready,
  output logic                 bclk,
  output logic                 lrck,
  output logic                 sdata,
  output logic [1:0]           fifo_level,
  output logic                 underrun,
  output logic                 overflow
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef struct packed {
    logic [DATA_SIZE-1:0] l;
    logic [DATA_SIZE-1:0] r;
  } pair_t;

  // Frame word: vector MSB is the first bit sent (left MSB); pad bits stay 0.
  function automatic logic [FRAME_BITS-1:0] frame_word(input pair_t p);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[FRAME_BITS-1 -: DATA_SIZE] = p.l;
    w[SLOT_BITS-1  -: DATA_SIZE] = p.r;
    return w;
  endfunction

  logic [DIV_W-1:0]      div_cnt;
  logic                  bclk_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      bit_nxt;
  logic                  lrck_q;
  logic [FRAME_BITS-1:0] shreg;
  pair_t                 last_pair;
  pair_t                 mem [2];
  pair_t                 head;
  pair_t                 in_pair;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  div_wrap, fall, frame_start;
  logic                  fifo_empty, push, pop;
  logic                  underrun_q, overflow_q;

  assign div_wrap    = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign fall        = div_wrap && bclk_q;
  assign frame_start = fall && (bit_cnt == '0);
  assign bit_nxt     = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;

  assign fifo_empty  = (count == 2'd0);
  assign head        = mem[rd_ptr];
  assign in_pair     = '{l: in_left, r: in_right};
  // Pop happens before push, so a full FIFO can accept a strobe at frame start.
  assign pop         = frame_start && !fifo_empty;
  assign push        = in_ready && ((count != 2'd2) || pop);

  // BCLK divider: toggle every BCLK_HALF clk cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      bclk_q  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk_q  <= ~bclk_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit position within the frame and word select, advanced on each fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      lrck_q  <= 1'b0;
    end else if (fall) begin
      bit_cnt <= bit_nxt;
      lrck_q  <= (bit_nxt >= BIT_W'(SLOT_BITS));
    end
  end

  // Two-entry pair FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_pair;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Frame shifter: load at frame start (fresh pair or repeat), shift on other falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      last_pair <= '0;
    end else if (frame_start) begin
      if (pop) begin
        shreg     <= frame_word(head);
        last_pair <= head;
      end else begin
        shreg     <= frame_word(last_pair);
      end
    end else if (fall) begin
      shreg <= shreg << 1;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      underrun_q <= frame_start && fifo_empty;
      overflow_q <= in_ready && !push;
    end
  end

  assign bclk       = bclk_q;
  assign lrck       = lrck_q;
  assign sdata      = shreg[FRAME_BITS-1];
  assign fifo_level = count;
  assign underrun   = underrun_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Scoreboard bench for i2s_sample_tx: a queue-based model predicts the frame
// contents and status pulses; a monitor deserialises sdata on bclk rises.
module tb_i2s_sample_tx;
  localparam int D  = 8;
  localparam int S  = 10;
  localparam int H  = 2;
  localparam int FB = 2 * S;
  localparam int P  = 2 * FB * H;   // clk cycles per frame

  typedef struct packed {
    logic [D-1:0] l;
    logic [D-1:0] r;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [D-1:0] in_left = '0, in_right = '0;
  logic         in_ready = 1'b0;
  logic         bclk, lrck, sdata, underrun, overflow;
  logic [1:0]   fifo_level;

  i2s_sample_tx #(.DATA_SIZE(D), .SLOT_BITS(S), .BCLK_HALF(H)) dut (
    .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right),
    .in_ready(in_ready), .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .fifo_level(fifo_level), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial order of a pair: slot by slot, data bits MSB first then zero padding.
  function automatic logic [FB-1:0] frame_of(input pair_t p);
    logic [FB-1:0] w;
    w = '0;
    for (int i = 0; i < FB; i++) begin
      int slot;
      int pos;
      slot = i / S;
      pos  = i % S;
      if (pos < D) w[FB-1-i] = (slot == 0) ? p.l[D-1-pos] : p.r[D-1-pos];
    end
    return w;
  endfunction

  // Reference model state.
  pair_t         mq[$];
  pair_t         last_p = '0;
  int            mcyc = 0;
  logic [FB-1:0] exp_frames[$];
  logic [1:0]    e_lvl = 2'd0;
  logic          e_ur = 1'b0, e_ov = 1'b0;

  // Model: frame starts at cycle 2H after release, then every P cycles.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      exp_frames.delete();
      last_p = '0;
      mcyc   = 0;
      e_lvl  = 2'd0;
      e_ur   = 1'b0;
      e_ov   = 1'b0;
    end else begin
      pair_t np;
      mcyc++;
      e_ur = 1'b0;
      e_ov = 1'b0;
      if (mcyc >= 2*H && ((mcyc - 2*H) % P) == 0) begin
        if (mq.size() > 0) last_p = mq.pop_front();
        else               e_ur = 1'b1;
        exp_frames.push_back(frame_of(last_p));
      end
      if (in_ready) begin
        np.l = in_left;
        np.r = in_right;
        if (mq.size() < 2) mq.push_back(np);
        else               e_ov = 1'b1;
      end
      e_lvl = 2'(mq.size());
    end
  end

  // Monitor: per-cycle status checks and frame deserialisation on bclk rises.
  int            rise_k = 0;
  logic          prev_bclk = 1'b0;
  logic [FB-1:0] acc = '0;
  initial forever begin
    @(negedge clk);
    check("fifo_level", 64'(fifo_level), 64'(e_lvl));
    check("underrun", 64'(underrun), 64'(e_ur));
    check("overflow", 64'(overflow), 64'(e_ov));
    if (!rst) begin
      rise_k    = 0;
      prev_bclk = 1'b0;
      acc       = '0;
    end else begin
      if (!prev_bclk && bclk) begin
        int b;
        b = rise_k % FB;
        check("lrck", 64'(lrck), 64'(b >= S));
        if (rise_k == 0) begin
          check("sdata_pre", 64'(sdata), 64'(0));
        end else begin
          int j;
          j = (rise_k - 1) % FB;
          acc[FB-1-j] = sdata;
          if (j == FB - 1) begin
            if (exp_frames.size() == 0) begin
              errors++;
              vectors++;
              $display("FAIL frame: got %0h expected none queued", acc);
            end else begin
              check("frame", 64'(acc), 64'(exp_frames.pop_front()));
            end
          end
        end
        rise_k++;
      end
      prev_bclk = bclk;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [D-1:0] l, input logic [D-1:0] r);
    in_left  = l;
    in_right = r;
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  // Park at the negedge right before a frame-start clk edge.
  task automatic wait_pre_fs();
    int guard;
    guard = 0;
    while (((mcyc + 1) < 2*H || ((mcyc + 1 - 2*H) % P) != 0) && guard < 2*P) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2*P) begin
      errors++;
      vectors++;
      $display("FAIL wait_pre_fs: timed out after %0d cycles, expected < %0d", guard, 2*P);
    end
  endtask

  initial begin
    // Reset, then single pair pushed before the first frame start.
    idle(3);
    rst = 1'b1;
    push(8'hA5, 8'h3C);
    idle(3*P);

    // Asynchronous reset mid-frame: outputs drop at once.
    idle(37);
    #2 rst = 1'b0;
    #1;
    check("rst_bclk", 64'(bclk), 64'(0));
    check("rst_lrck", 64'(lrck), 64'(0));
    check("rst_sdata", 64'(sdata), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_underrun", 64'(underrun), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    idle(3);
    rst = 1'b1;

    // Overflow: three back-to-back strobes into an empty FIFO.
    push(8'h11, 8'h22);
    push(8'h33, 8'h44);
    push(8'h55, 8'h66);
    idle(4);
    // Refill to full, then strobe exactly on a frame start.
    push(8'h77, 8'h88);
    wait_pre_fs();
    push(8'h99, 8'hAA);
    idle(4*P);

    // Random streaming, roughly one pair per frame with occasional extras.
    for (int f = 0; f < 30; f++) begin
      wait_pre_fs();
      idle($urandom_range(1, P - 4));
      push(D'($urandom), D'($urandom));
      if ($urandom_range(0, 3) == 0) push(D'($urandom), D'($urandom));
    end

    // Random strobe bursts to stress overflow and simultaneous push/pop.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 2) == 0) push(D'($urandom), D'($urandom));
      else idle(1);
    end
    idle(3*P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
